// File: rtl/bp_be_mul_issue_tracker.sv
// Issue handshake, kill-aware result tracking and credit-protected writeback buffer for the
// backend multiply pipe. Optional macro BP_BE_MUL_WB_BYPASS_EN: empty-buffer writeback bypass.
module bp_be_mul_issue_tracker #(
    parameter int LATENCY   = 4,
    parameter int BUF_DEPTH = 4,
    parameter int DATA_W    = 64,
    parameter int DECODE_W  = 51,
    parameter int RD_W      = 5
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                issue_v_i,
    output logic                issue_ready_o,
    input  logic [DECODE_W-1:0] issue_decode_i,
    input  logic [DATA_W-1:0]   issue_rs1_i,
    input  logic [DATA_W-1:0]   issue_rs2_i,
    input  logic [RD_W-1:0]     issue_rd_i,
    input  logic                kill_ex1_i,
    input  logic                kill_ex2_i,
    output logic                pipe_v_o,
    output logic [DECODE_W-1:0] pipe_decode_o,
    output logic [DATA_W-1:0]   pipe_rs1_o,
    output logic [DATA_W-1:0]   pipe_rs2_o,
    input  logic [DATA_W-1:0]   pipe_data_i,
    output logic                wb_v_o,
    input  logic                wb_ready_i,
    output logic [RD_W-1:0]     wb_rd_o,
    output logic [DATA_W-1:0]   wb_data_o,
    output logic [3:0]          inflight_o
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [CNT_W-1:0]  credits;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [RD_W-1:0]   buf_rd   [BUF_DEPTH];
    logic [DATA_W-1:0] buf_data [BUF_DEPTH];

    // Tracking stage index k-1 holds s[k]: index 0 is EX1, index 1 is EX2.
    logic [LATENCY-1:0] stage_v;
    logic [LATENCY-1:0] next_v;
    logic [RD_W-1:0]    stage_rd [LATENCY];

    logic acc;
    logic empty;
    logic kill1;
    logic kill2;
    logic cap_v;
    logic pop;
    logic bypass;
    logic push;

    assign issue_ready_o = (credits != '0);
    assign acc           = issue_v_i & issue_ready_o;
    assign pipe_v_o      = acc;
    assign pipe_decode_o = acc ? issue_decode_i : '0;
    assign pipe_rs1_o    = issue_rs1_i;
    assign pipe_rs2_o    = issue_rs2_i;

    assign empty = (count == '0);
    assign kill1 = kill_ex1_i & stage_v[0];
    assign kill2 = kill_ex2_i & stage_v[1];
    // With a two-cycle pipe the EX2 op is also the one being captured, so its kill blocks capture.
    assign cap_v = stage_v[LATENCY-1] & ~((LATENCY == 2) & kill_ex2_i);

`ifdef BP_BE_MUL_WB_BYPASS_EN
    assign bypass    = empty & cap_v & wb_ready_i;
    assign wb_v_o    = ~empty | cap_v;
    assign wb_rd_o   = !empty ? buf_rd[head]   : (cap_v ? stage_rd[LATENCY-1] : '0);
    assign wb_data_o = !empty ? buf_data[head] : (cap_v ? pipe_data_i : '0);
`else
    assign bypass    = 1'b0;
    assign wb_v_o    = ~empty;
    assign wb_rd_o   = empty ? '0 : buf_rd[head];
    assign wb_data_o = empty ? '0 : buf_data[head];
`endif

    assign pop  = ~empty & wb_ready_i;
    assign push = cap_v & ~bypass;

    assign inflight_o = 4'(BUF_DEPTH) - 4'(credits);

    always_comb begin
        next_v    = '0;
        next_v[0] = acc;
        for (int k = 1; k < LATENCY; k++) begin
            if (k == 1) begin
                next_v[k] = stage_v[k-1] & ~kill_ex1_i;
            end else if (k == 2) begin
                next_v[k] = stage_v[k-1] & ~kill_ex2_i;
            end else begin
                next_v[k] = stage_v[k-1];
            end
        end
    end

    // Every credit return (pop, bypass consume, kills) nets against an accept in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            stage_v <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            credits <= CNT_W'(BUF_DEPTH);
        end else begin
            stage_v <= next_v;
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count   <= count + CNT_W'(push) - CNT_W'(pop);
            credits <= credits + CNT_W'(pop) + CNT_W'(bypass) + CNT_W'(kill1) + CNT_W'(kill2)
                       - CNT_W'(acc);
        end
    end

    always_ff @(posedge clk_i) begin
        stage_rd[0] <= issue_rd_i;
        for (int k = 1; k < LATENCY; k++) begin
            stage_rd[k] <= stage_rd[k-1];
        end
        if (push) begin
            buf_rd[tail]   <= stage_rd[LATENCY-1];
            buf_data[tail] <= pipe_data_i;
        end
    end
endmodule

// File: tb/tb_bp_be_mul_issue_tracker.sv
// Randomized self-checking bench for bp_be_mul_issue_tracker against a queue-based op model.
// Honours BP_BE_MUL_WB_BYPASS_EN the same way as the design.
module tb_bp_be_mul_issue_tracker;
    localparam int LATENCY   = 4;
    localparam int BUF_DEPTH = 4;
    localparam int NUM_CYCLES = 3000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        issue_v;
    logic        issue_ready;
    logic [50:0] issue_decode;
    logic [63:0] issue_rs1;
    logic [63:0] issue_rs2;
    logic [4:0]  issue_rd;
    logic        kill_ex1;
    logic        kill_ex2;
    logic        pipe_v;
    logic [50:0] pipe_decode;
    logic [63:0] pipe_rs1;
    logic [63:0] pipe_rs2;
    logic [63:0] pipe_data;
    logic        wb_v;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic [3:0]  inflight;

    int num_compared   = 0;
    int num_mismatched = 0;

    bp_be_mul_issue_tracker #(
        .LATENCY(LATENCY), .BUF_DEPTH(BUF_DEPTH), .DATA_W(64), .DECODE_W(51), .RD_W(5)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .issue_v_i(issue_v), .issue_ready_o(issue_ready), .issue_decode_i(issue_decode),
        .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2), .issue_rd_i(issue_rd),
        .kill_ex1_i(kill_ex1), .kill_ex2_i(kill_ex2),
        .pipe_v_o(pipe_v), .pipe_decode_o(pipe_decode), .pipe_rs1_o(pipe_rs1),
        .pipe_rs2_o(pipe_rs2), .pipe_data_i(pipe_data),
        .wb_v_o(wb_v), .wb_ready_i(wb_ready), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
        .inflight_o(inflight)
    );

    always #5 clk = ~clk;

    // Model: each live op remembers how many cycles it has been in flight; results wait in a queue.
    typedef struct { logic [4:0] rd; int age; } op_t;
    typedef struct { logic [4:0] rd; logic [63:0] data; } wb_t;
    op_t track_q[$];
    wb_t wb_q[$];

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        num_compared++;
        if (observed !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst_n, input logic v, input logic [4:0] rd,
                                 input logic k1, input logic k2, input logic wbr,
                                 input logic [63:0] data);
        reset_n      = rst_n;
        issue_v      = v;
        issue_rd     = rd;
        kill_ex1     = k1;
        kill_ex2     = k2;
        wb_ready     = wbr;
        pipe_data    = data;
        issue_decode = 51'({$urandom, $urandom});
        issue_rs1    = {$urandom, $urandom};
        issue_rs2    = {$urandom, $urandom};
    endtask

    function automatic int findCapture();
        foreach (track_q[i]) begin
            if (track_q[i].age == LATENCY && !(LATENCY == 2 && kill_ex2)) return i;
        end
        return -1;
    endfunction

    task automatic checkCycle();
        int   live;
        bit   exp_ready;
        bit   exp_acc;
        bit   exp_wb_v;
        bit   ovf;
        logic [4:0]  exp_rd;
        logic [63:0] exp_data;
        live      = track_q.size() + wb_q.size();
        exp_ready = live < BUF_DEPTH;
        exp_acc   = issue_v && exp_ready;
        exp_wb_v  = wb_q.size() != 0;
        exp_rd    = exp_wb_v ? wb_q[0].rd : 5'd0;
        exp_data  = exp_wb_v ? wb_q[0].data : 64'd0;
`ifdef BP_BE_MUL_WB_BYPASS_EN
        if (!exp_wb_v && findCapture() >= 0) begin
            exp_wb_v = 1'b1;
            exp_rd   = track_q[findCapture()].rd;
            exp_data = pipe_data;
        end
`endif
        checkOutput("issue_ready", 64'(issue_ready), 64'(exp_ready));
        checkOutput("pipe_v", 64'(pipe_v), 64'(exp_acc));
        checkOutput("pipe_decode", 64'(pipe_decode), exp_acc ? 64'(issue_decode) : 64'd0);
        checkOutput("pipe_rs1", pipe_rs1, issue_rs1);
        checkOutput("pipe_rs2", pipe_rs2, issue_rs2);
        checkOutput("inflight", 64'(inflight), 64'(live));
        checkOutput("wb_v", 64'(wb_v), 64'(exp_wb_v));
        if (exp_wb_v) begin
            checkOutput("wb_rd", 64'(wb_rd), 64'(exp_rd));
            checkOutput("wb_data", wb_data, exp_data);
        end
        ovf = dut.push && (int'(dut.count) == BUF_DEPTH) && !dut.pop;
        checkOutput("no_fifo_overflow", 64'(ovf), 64'd0);
        assert (!ovf);
    endtask

    task automatic modelStep();
        op_t nt[$];
        op_t o;
        wb_t cap;
        bit  have_cap = 1'b0;
        bit  pop;
        bit  acc;
        if (!reset_n) begin
            track_q.delete();
            wb_q.delete();
            return;
        end
        acc = issue_v && ((track_q.size() + wb_q.size()) < BUF_DEPTH);
        pop = (wb_q.size() != 0) && wb_ready;
        foreach (track_q[i]) begin
            o = track_q[i];
            if (o.age == 1 && kill_ex1) begin
                // squashed in EX1
            end else if (o.age == 2 && kill_ex2) begin
                // squashed in EX2
            end else if (o.age == LATENCY) begin
                cap.rd   = o.rd;
                cap.data = pipe_data;
                have_cap = 1'b1;
            end else begin
                o.age++;
                nt.push_back(o);
            end
        end
`ifdef BP_BE_MUL_WB_BYPASS_EN
        if (have_cap && wb_q.size() == 0 && wb_ready) have_cap = 1'b0;
`endif
        if (pop) void'(wb_q.pop_front());
        if (have_cap) wb_q.push_back(cap);
        if (acc) begin
            o.rd  = issue_rd;
            o.age = 1;
            nt.push_back(o);
        end
        track_q = nt;
    endtask

    initial begin
        int  mode;
        bit  rst_n;
        bit  wbr;
        bit  prev_reset;
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0);
        #1;
        checkOutput("reset_issue_ready", 64'(issue_ready), 64'd1);
        checkOutput("reset_wb_v", 64'(wb_v), 64'd0);
        checkOutput("reset_wb_rd", 64'(wb_rd), 64'd0);
        checkOutput("reset_wb_data", wb_data, 64'd0);
        checkOutput("reset_inflight", 64'(inflight), 64'd0);
        checkOutput("reset_pipe_v", 64'(pipe_v), 64'd0);

        mode       = 2;
        prev_reset = 1'b0;
        for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
            if (cyc % 48 == 0) mode = $urandom_range(0, 3);
            case (mode)
                0:       wbr = 1'b0;
                1:       wbr = 1'($urandom_range(0, 1));
                2:       wbr = 1'b1;
                default: wbr = cyc[0];
            endcase
            rst_n = !(cyc == 1500 || $urandom_range(0, 299) == 0);
            if (cyc < 10) begin
                // Lone op rd=7 with a fixed result value, drained freely.
                applyStimulus(1'b1, cyc == 0, 5'd7, 1'b0, 1'b0, 1'b1, 64'h1234);
            end else begin
                applyStimulus(rst_n, $urandom_range(0, 9) < 8, 5'($urandom),
                              $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, wbr,
                              {$urandom, $urandom});
            end
            #1;
            if (prev_reset) begin
                checkOutput("post_reset_wb_v", 64'(wb_v), 64'd0);
                checkOutput("post_reset_ready", 64'(issue_ready), 64'd1);
                checkOutput("post_reset_inflight", 64'(inflight), 64'd0);
            end
            checkCycle();
            prev_reset = !reset_n;
            modelStep();
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end
endmodule
